// File: rtl/root_calc_controller.sv
// Root calculator sequencer: accepts operand words, launches the root core,
// waits for its result (with timeout), and streams the result MSB-first.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_word, in_word_ready    operand word and its 1-cycle valid pulse
//   core_operand, core_start  operand held for the core and its start pulse
//   core_done, core_result    core completion pulse and result
//   tx_data, tx_data_ready    byte and 1-cycle valid pulse to the transmitter
//   tx_busy                   transmitter busy; a byte is issued only when low
//   busy                      high whenever an operation is in progress
//   result_valid              1-cycle pulse after the last byte is issued
//   timeout_err               sticky core timeout flag
//   drop_count                saturating count of words dropped while busy
module root_calc_controller #(
   parameter int RESULT_WIDTH   = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter logic [RESULT_WIDTH-1:0] ERR_PATTERN = '1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             in_word,
   input  logic                    in_word_ready,
   output logic [31:0]             core_operand,
   output logic                    core_start,
   input  logic                    core_done,
   input  logic [RESULT_WIDTH-1:0] core_result,
   output logic [7:0]              tx_data,
   output logic                    tx_data_ready,
   input  logic                    tx_busy,
   output logic                    busy,
   output logic                    result_valid,
   output logic                    timeout_err,
   output logic [7:0]              drop_count
);

   localparam int N_BYTES = RESULT_WIDTH / 8;
   localparam int CW      = $clog2(N_BYTES + 1);
   localparam int TW      = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_SEND,
      S_GAP,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [31:0]             operand_q, operand_d;
   logic                    start_q, start_d;
   logic [7:0]              txd_q, txd_d;
   logic                    txr_q, txr_d;
   logic                    busy_q, busy_d;
   logic                    rv_q, rv_d;
   logic                    terr_q, terr_d;
   logic [7:0]              drop_q, drop_d;
   logic [TW-1:0]           timer_q, timer_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [RESULT_WIDTH-1:0] shift_q, shift_d;

   // Output registers are loaded with the value belonging to the state being
   // entered, so each pulse appears during the cycle of its state.
   always_comb begin
      state_d   = state_q;
      operand_d = operand_q;
      start_d   = 1'b0;
      txd_d     = txd_q;
      txr_d     = 1'b0;
      rv_d      = 1'b0;
      terr_d    = terr_q;
      drop_d    = drop_q;
      timer_d   = timer_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;

      if (in_word_ready && state_q != S_IDLE && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;

      unique case (state_q)
         S_IDLE: begin
            if (in_word_ready) begin
               operand_d = in_word;
               start_d   = 1'b1;
               state_d   = S_START;
            end
         end
         S_START: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + TW'(1);
            // A result arriving on the timeout cycle still wins.
            if (core_done) begin
               shift_d = core_result;
               cnt_d   = CW'(N_BYTES);
               state_d = S_SEND;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               shift_d = ERR_PATTERN;
               terr_d  = 1'b1;
               cnt_d   = CW'(N_BYTES);
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               txd_d   = shift_q[RESULT_WIDTH-1 -: 8];
               txr_d   = 1'b1;
               shift_d = shift_q << 8;
               cnt_d   = cnt_q - CW'(1);
               state_d = S_GAP;
            end
         end
         // Gives the transmitter a cycle to raise tx_busy.
         S_GAP: begin
            if (cnt_q != '0) begin
               state_d = S_SEND;
            end else begin
               rv_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         operand_q <= '0;
         start_q   <= 1'b0;
         txd_q     <= '0;
         txr_q     <= 1'b0;
         busy_q    <= 1'b0;
         rv_q      <= 1'b0;
         terr_q    <= 1'b0;
         drop_q    <= '0;
         timer_q   <= '0;
         cnt_q     <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         operand_q <= operand_d;
         start_q   <= start_d;
         txd_q     <= txd_d;
         txr_q     <= txr_d;
         busy_q    <= busy_d;
         rv_q      <= rv_d;
         terr_q    <= terr_d;
         drop_q    <= drop_d;
         timer_q   <= timer_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
      end
   end

   assign core_operand  = operand_q;
   assign core_start    = start_q;
   assign tx_data       = txd_q;
   assign tx_data_ready = txr_q;
   assign busy          = busy_q;
   assign result_valid  = rv_q;
   assign timeout_err   = terr_q;
   assign drop_count    = drop_q;

endmodule

// File: tb/tb_root_calc_controller.sv
// Directed testbench for root_calc_controller.
// Core and transmitter are modelled by simple stimulus processes.
module tb_root_calc_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_word;
   logic        in_word_ready;
   logic [31:0] core_operand;
   logic        core_start;
   logic        core_done;
   logic [15:0] core_result;
   logic [7:0]  tx_data;
   logic        tx_data_ready;
   logic        tx_busy;
   logic        busy;
   logic        result_valid;
   logic        timeout_err;
   logic [7:0]  drop_count;

   root_calc_controller #(
      .RESULT_WIDTH   (16),
      .TIMEOUT_CYCLES (16),
      .ERR_PATTERN    (16'hFFFF)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_word       (in_word),
      .in_word_ready (in_word_ready),
      .core_operand  (core_operand),
      .core_start    (core_start),
      .core_done     (core_done),
      .core_result   (core_result),
      .tx_data       (tx_data),
      .tx_data_ready (tx_data_ready),
      .tx_busy       (tx_busy),
      .busy          (busy),
      .result_valid  (result_valid),
      .timeout_err   (timeout_err),
      .drop_count    (drop_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Event log sampled on the falling edge.
   int         n_start;
   int         start_cyc;
   int         n_rv;
   int         rv_cyc;
   logic [7:0] bytes[$];
   int         bcyc[$];

   always @(negedge clk) begin
      if (core_start) begin
         n_start   <= n_start + 1;
         start_cyc <= cyc;
      end
      if (tx_data_ready) begin
         bytes.push_back(tx_data);
         bcyc.push_back(cyc);
      end
      if (result_valid) begin
         n_rv   <= n_rv + 1;
         rv_cyc <= cyc;
      end
   end

   // Core model: answers core_delay cycles after core_start (0 = never).
   int          core_delay;
   logic [15:0] resp;
   int          cd_cnt;

   initial begin
      core_done   = 1'b0;
      core_result = '0;
      cd_cnt      = 0;
      forever begin
         @(posedge clk);
         #1;
         core_done = 1'b0;
         if (cd_cnt > 0) begin
            cd_cnt--;
            if (cd_cnt == 0) begin
               core_done   = 1'b1;
               core_result = resp;
            end
         end
         if (core_start && core_delay > 0)
            cd_cnt = core_delay;
      end
   end

   int acc;

   task automatic clear_mon();
      n_start = 0;
      n_rv    = 0;
      bytes.delete();
      bcyc.delete();
   endtask

   task automatic send_word(input logic [31:0] w);
      @(posedge clk);
      #1;
      in_word       = w;
      in_word_ready = 1'b1;
      acc           = cyc;
      @(posedge clk);
      #1;
      in_word_ready = 1'b0;
   endtask

   task automatic wait_rv(input int n);
      int k;
      k = 0;
      while (n_rv < n && k < 400) begin
         @(negedge clk);
         #1;
         k++;
      end
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic wait_byte();
      int k;
      k = 0;
      while (bytes.size() < 1 && k < 400) begin
         @(negedge clk);
         #1;
         k++;
      end
   endtask

   task automatic check_two(input string tag, input logic [7:0] b0,
                            input logic [7:0] b1);
      check_eq({tag, "_nbytes"}, bytes.size(), 2);
      if (bytes.size() == 2) begin
         check_eq({tag, "_b0"}, bytes[0], b0);
         check_eq({tag, "_b1"}, bytes[1], b1);
      end
      check_eq({tag, "_nrv"}, n_rv, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic stable;
      rst           = 1'b1;
      in_word       = '0;
      in_word_ready = 1'b0;
      tx_busy       = 1'b0;
      core_delay    = 0;
      resp          = '0;
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_outs",
               {busy, core_start, tx_data_ready, result_valid, timeout_err},
               0);
      check_eq("rst_operand", core_operand, 0);
      check_eq("rst_txdata", tx_data, 0);
      check_eq("rst_drop", drop_count, 0);
      rst = 1'b0;

      // Basic operation: 144 -> 12.
      clear_mon();
      core_delay = 5;
      resp       = 16'd12;
      send_word(32'd144);
      wait_rv(1);
      check_eq("t1_start_cyc", start_cyc, acc + 1);
      check_eq("t1_nstart", n_start, 1);
      check_eq("t1_operand", core_operand, 144);
      check_two("t1", 8'h00, 8'h0C);
      if (bcyc.size() == 2) begin
         check_eq("t1_b0_cyc", bcyc[0], acc + 8);
         check_eq("t1_spacing", bcyc[1] - bcyc[0], 2);
      end
      check_eq("t1_rv_cyc", rv_cyc, acc + 11);
      check_eq("t1_drop", drop_count, 0);
      check_eq("t1_idle", busy, 0);

      // Transmitter back-pressure after first byte.
      clear_mon();
      core_delay = 3;
      resp       = 16'hABCD;
      send_word(32'd7);
      wait_byte();
      tx_busy = 1'b1;
      stable  = 1'b1;
      repeat (10) begin
         @(negedge clk);
         #1;
         if (tx_data !== 8'hAB || bytes.size() != 1)
            stable = 1'b0;
      end
      check_eq("t2_held", stable, 1);
      tx_busy = 1'b0;
      wait_rv(1);
      check_two("t2", 8'hAB, 8'hCD);
      if (bcyc.size() == 2)
         check_eq("t2_b1_cyc", bcyc[1] - bcyc[0], 11);

      // core_done coincides with the timeout cycle.
      clear_mon();
      core_delay = 16;
      resp       = 16'h0102;
      send_word(32'd9);
      wait_rv(1);
      check_two("t6", 8'h01, 8'h02);
      check_eq("t6_terr", timeout_err, 0);

      // Core never answers.
      clear_mon();
      core_delay = 0;
      send_word(32'd11);
      wait_rv(1);
      check_two("t3", 8'hFF, 8'hFF);
      if (bcyc.size() == 2)
         check_eq("t3_b0_cyc", bcyc[0], acc + 19);
      check_eq("t3_terr", timeout_err, 1);
      clear_mon();
      core_delay = 2;
      resp       = 16'h1234;
      send_word(32'd13);
      wait_rv(1);
      check_two("t3b", 8'h12, 8'h34);
      check_eq("t3b_terr", timeout_err, 1);

      // 300 words while busy, held in SEND by tx_busy.
      clear_mon();
      core_delay = 2;
      resp       = 16'h7788;
      tx_busy    = 1'b1;
      for (int i = 0; i <= 300; i++) begin
         @(posedge clk);
         #1;
         in_word       = (i == 0) ? 32'h55 : 32'(1000 + i);
         in_word_ready = 1'b1;
         if (i == 0)
            acc = cyc;
         if (i == 11)
            check_eq("t4_drop10", drop_count, 10);
      end
      @(posedge clk);
      #1;
      in_word_ready = 1'b0;
      check_eq("t4_drop_sat", drop_count, 255);
      check_eq("t4_operand", core_operand, 32'h55);
      check_eq("t4_nstart", n_start, 1);
      check_eq("t4_nobytes", bytes.size(), 0);
      tx_busy = 1'b0;
      wait_rv(1);
      check_two("t4", 8'h77, 8'h88);
      check_eq("t4_drop_hold", drop_count, 255);

      // Reset in SEND after first byte.
      clear_mon();
      core_delay = 2;
      resp       = 16'hBEEF;
      send_word(32'd21);
      wait_byte();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("t5_outs",
               {busy, core_start, tx_data_ready, result_valid, timeout_err},
               0);
      check_eq("t5_operand", core_operand, 0);
      check_eq("t5_txdata", tx_data, 0);
      check_eq("t5_drop", drop_count, 0);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      check_eq("t5_nbytes", bytes.size(), 1);
      check_eq("t5_nrv", n_rv, 0);
      clear_mon();
      core_delay = 4;
      resp       = 16'h0020;
      send_word(32'h400);
      wait_rv(1);
      check_two("t5b", 8'h00, 8'h20);
      check_eq("t5b_operand", core_operand, 32'h400);
      check_eq("t5b_terr", timeout_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
